m68k_bus_arbiter_nreg: RTL and testbench
========================================

Name: m68k_bus_arbiter_nreg

Overview:
- Parametrised 68040 bus-cycle controller: decodes the upper address bits of each TS-started cycle into NREG regions and drives a one-hot select.
- Per region: counted wait states or an external ack, burst (line) or burst-inhibit, and a watchdog timeout; answers the CPU with TA, TEA or TA+TBI.
- Sits between the 68040 bus pins and the ROM/RAM/UART/FPGA-register decode, replacing the fixed four-target decoder.

Parameters:
- NREG, 4, number of decoded regions.
- AW, 32, address width.
- DB, 4, decoded top address bits (a[AW-1 -: DB]).
- REG_BASE, {4'h8,4'h3,4'h2,4'h0}, packed NREG*DB region tags; region i matches when the top bits equal tag i; the lowest index wins.
- REG_WAIT, {4'd0,4'd5,4'd3,4'd2}, packed NREG*4 wait-state counts per beat.
- REG_EXT, 4'b0110, region i uses ext_ack[i] instead of its wait count.
- REG_BURST, 4'b0001, region i supports 4-beat line transfers.
- TIMEOUT, 255, watchdog in clocks per beat (TW = clog2(TIMEOUT+1)).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ts_n  in  1  transfer start, active-low
- a  in  AW  address
- rw  in  1  1 = read
- siz  in  2  00 long, 01 byte, 10 word, 11 line
- ta_n  out  1  transfer acknowledge, active-low
- tea_n  out  1  transfer error, active-low
- tbi_n  out  1  burst inhibit, active-low, valid with ta_n
- sel  out  NREG  one-hot region select
- ext_ack  in  NREG  per-region completion, active-high pulse, ignored unless selected
- busy  out  1  cycle in progress
- err_stb  out  1  one-clock pulse on every TEA
- err_addr  out  AW  address of the last errored cycle

Behaviour:
- Reset values: ta_n=1, tea_n=1, tbi_n=1, sel=0, busy=0, err_stb=0, err_addr=0, state IDLE. Reset mid-cycle aborts immediately with no TA or TEA.
- All outputs are registered.
- States: IDLE, WAIT, ACK, ERR.
- IDLE: when ts_n is sampled low at edge k:
  - latch a, rw, siz, and the region hit; busy=1.
  - If a region hits: sel=onehot at edge k; beats = (siz==11 && REG_BURST[i]) ? 4 : 1; wcnt=REG_WAIT[i]; tmo=0; go to WAIT.
  - If no region hits: go to ERR.
- WAIT, counted region: if wcnt==0, go to ACK; else wcnt decrements.
- WAIT, ext region: ext_ack[i] high moves to ACK. Otherwise tmo increments, and tmo==TIMEOUT moves to ERR.
- Latency, counted region: ta_n is low during the clock after edge k+1+W (W=0 gives TA one clock after the TS-sample clock).
- ACK: ta_n=0 for exactly one clock.
  - tbi_n=0 in the same clock only if siz==11 and the region has no burst support; the cycle then ends after that beat (CPU reruns it as longwords).
  - If beats remain: decrement beats, reload wcnt and tmo, return to WAIT; ta_n returns high for at least one clock between beats, even with W=0.
  - On the last beat: sel=0, busy=0, back to IDLE at the next edge.
- ERR: tea_n=0 and err_stb=1 for one clock; err_addr=latched address; sel=0, busy=0; then IDLE. A timeout mid-burst aborts the remaining beats.
- ta_n and tea_n are never low together.
- ts_n low while busy is ignored: no relatch, the current cycle is unaffected.
- ext_ack on a non-selected region, or while IDLE, is ignored.
- ext_ack arriving in the same clock that tmo reaches TIMEOUT: ack wins.
- Overlapping REG_BASE tags: the lowest index wins.
- Wait counter is 4-bit, so 15 is the maximum wait count.
- Timeout counter is TW bits and saturates; it never wraps before reaching TIMEOUT.
- Read/write direction does not change the timing.

Test Plan:
- Long read at 0x0000_1000 (region 0, W=2) -> sel=0001 from the next edge; ta_n low exactly 1 clock, 4 clocks after the TS-sample edge; tbi_n=1.
- Line read at 0x0000_0100 (region 0, burst) -> four ta_n pulses, each preceded by 2 wait clocks and separated by a high clock; busy drops after the 4th.
- Line read at 0x3000_0000 (region 2, ext, no burst), ext_ack[2] pulsed 6 clocks later -> one ta_n with tbi_n=0 in the same clock, cycle ends.
- Access at 0x5000_0000 (unmapped) -> tea_n low for 1 clock, one clock after the TS sample; err_stb pulse; err_addr=0x5000_0000; ta_n stays high.
- Region 1 access with ext_ack never asserted, TIMEOUT=255 -> tea_n after 255 wait clocks; a second ts_n pulse injected mid-wait has no effect.
- Assert rst during a burst's 2nd wait clock -> all outputs at reset values the same clock; the next ts_n is serviced normally.

Source files
------------

// File: rtl/m68k_bus_arbiter_nreg.sv
// m68k_bus_arbiter_nreg
// 68040 bus-cycle controller. Each TS-started cycle is decoded by its top
// address bits into one of NREG regions. The controller drives a one-hot
// region select, counts wait states or waits for an external acknowledge,
// sequences 4-beat line transfers where the region allows them, and answers
// the CPU with TA, TEA or TA+TBI. A per-beat watchdog turns a missing external
// acknowledge into a bus error. All outputs come straight from flops.

module m68k_bus_arbiter_nreg #(
  parameter int                 NREG      = 4,
  parameter int                 AW        = 32,
  parameter int                 DB        = 4,
  parameter logic [NREG*DB-1:0] REG_BASE  = {4'h8, 4'h3, 4'h2, 4'h0},
  parameter logic [NREG*4-1:0]  REG_WAIT  = {4'd0, 4'd5, 4'd3, 4'd2},
  parameter logic [NREG-1:0]    REG_EXT   = 4'b0110,
  parameter logic [NREG-1:0]    REG_BURST = 4'b0001,
  parameter int                 TIMEOUT   = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ts_n,
  input  logic [AW-1:0]   a,
  input  logic            rw,
  input  logic [1:0]      siz,
  output logic            ta_n,
  output logic            tea_n,
  output logic            tbi_n,
  output logic [NREG-1:0] sel,
  input  logic [NREG-1:0] ext_ack,
  output logic            busy,
  output logic            err_stb,
  output logic [AW-1:0]   err_addr
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  // Watchdog limit compared against the incremented count (one extra bit so
  // the compare never aliases), and the saturation value of the counter.
  localparam logic [TW:0]   TMO_LIMIT = TIMEOUT[TW:0];
  localparam logic [TW-1:0] TMO_MAX   = TIMEOUT[TW-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Per-cycle context captured when TS is accepted.
  logic [AW-1:0]   addr_q, addr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [1:0]      beats_q, beats_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            inh_q, inh_d;

  // Next values of the registered outputs.
  logic            ta_d, tea_d, tbi_d, busy_d, stb_d;
  logic [NREG-1:0] sel_d;
  logic [AW-1:0]   eaddr_d;

  // Region decode of the live address bus.
  logic            hit;
  logic [IW-1:0]   hit_idx;
  logic [NREG-1:0] hit_onehot;
  logic [3:0]      hit_wait;
  logic            hit_burst;
  logic            is_line;

  // Properties of the region owning the cycle in flight.
  logic [3:0]      cur_wait;
  logic            ext_sel;
  logic            ack_sel;
  logic [TW:0]     tmo_inc;
  logic            tmo_expired;
  logic            wait_done;

  // The transfer direction has no influence on timing; it is deliberately
  // left out of the datapath.
  logic            unused_rw;
  assign unused_rw = rw;

  assign hit_wait    = REG_WAIT[{hit_idx, 2'b00} +: 4];
  assign hit_burst   = REG_BURST[hit_idx];
  assign is_line     = (siz == 2'b11);

  assign cur_wait    = REG_WAIT[{idx_q, 2'b00} +: 4];
  assign ext_sel     = REG_EXT[idx_q];
  assign ack_sel     = ext_ack[idx_q];
  assign tmo_inc     = {1'b0, tmo_q} + 1'b1;
  assign tmo_expired = (tmo_inc == TMO_LIMIT);
  assign wait_done   = (wcnt_q == 4'd0);

  // Match the top address bits against every region tag; scanning from the
  // highest index down lets the lowest matching index win on overlaps.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    hit_onehot = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (a[AW-1 -: DB] == REG_BASE[i*DB +: DB]) begin
        hit             = 1'b1;
        hit_idx         = IW'(i);
        hit_onehot      = '0;
        hit_onehot[i]   = 1'b1;
      end
    end
  end

  // State register plus every registered output and context field.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      idx_q    <= '0;
      beats_q  <= '0;
      wcnt_q   <= '0;
      tmo_q    <= '0;
      inh_q    <= 1'b0;
      ta_n     <= 1'b1;
      tea_n    <= 1'b1;
      tbi_n    <= 1'b1;
      sel      <= '0;
      busy     <= 1'b0;
      err_stb  <= 1'b0;
      err_addr <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      idx_q    <= idx_d;
      beats_q  <= beats_d;
      wcnt_q   <= wcnt_d;
      tmo_q    <= tmo_d;
      inh_q    <= inh_d;
      ta_n     <= ta_d;
      tea_n    <= tea_d;
      tbi_n    <= tbi_d;
      sel      <= sel_d;
      busy     <= busy_d;
      err_stb  <= stb_d;
      err_addr <= eaddr_d;
    end
  end

  // Next-state decision: accept TS only when idle, leave WAIT on completion
  // (an external ack beats a simultaneous watchdog expiry), loop back to
  // WAIT while line beats remain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!ts_n) begin
          state_d = hit ? WAIT : ERR;
        end
      end
      WAIT: begin
        if (ext_sel) begin
          if (ack_sel) begin
            state_d = ACK;
          end else if (tmo_expired) begin
            state_d = ERR;
          end
        end else if (wait_done) begin
          state_d = ACK;
        end
      end
      ACK: begin
        state_d = (beats_q != 2'd0) ? WAIT : IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next values for outputs and cycle context, so that TA/TEA/TBI appear in
  // the clock of the ACK/ERR state and select/busy follow the cycle exactly.
  always_comb begin
    addr_d  = addr_q;
    idx_d   = idx_q;
    beats_d = beats_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    inh_d   = inh_q;
    ta_d    = 1'b1;
    tea_d   = 1'b1;
    tbi_d   = 1'b1;
    sel_d   = sel;
    busy_d  = busy;
    stb_d   = 1'b0;
    eaddr_d = err_addr;
    unique case (state_q)
      IDLE: begin
        if (!ts_n) begin
          addr_d = a;
          idx_d  = hit_idx;
          busy_d = 1'b1;
          if (hit) begin
            sel_d   = hit_onehot;
            beats_d = (is_line && hit_burst) ? 2'd3 : 2'd0;
            inh_d   = is_line && !hit_burst;
            wcnt_d  = hit_wait;
            tmo_d   = '0;
          end else begin
            tea_d   = 1'b0;
            stb_d   = 1'b1;
            eaddr_d = a;
            sel_d   = '0;
          end
        end
      end
      WAIT: begin
        if (ext_sel) begin
          if (ack_sel) begin
            ta_d  = 1'b0;
            tbi_d = ~inh_q;
          end else if (tmo_expired) begin
            tea_d   = 1'b0;
            stb_d   = 1'b1;
            eaddr_d = addr_q;
            sel_d   = '0;
          end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
          end
        end else if (wait_done) begin
          ta_d  = 1'b0;
          tbi_d = ~inh_q;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ACK: begin
        if (beats_q != 2'd0) begin
          beats_d = beats_q - 2'd1;
          wcnt_d  = cur_wait;
          tmo_d   = '0;
        end else begin
          sel_d  = '0;
          busy_d = 1'b0;
        end
      end
      ERR: begin
        sel_d  = '0;
        busy_d = 1'b0;
      end
      default: begin
        sel_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_m68k_bus_arbiter_nreg.sv
// tb_m68k_bus_arbiter_nreg
// Directed bench for the 68040 bus-cycle controller. A transaction-level
// model predicts every output each clock from the region table and the
// latency rules; directed sequences also pin key moments to literal values.

module tb_m68k_bus_arbiter_nreg;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        rst;
  logic        ts_n;
  logic [31:0] a;
  logic        rw;
  logic [1:0]  siz;
  logic [3:0]  ext_ack;
  logic        ta_n;
  logic        tea_n;
  logic        tbi_n;
  logic [3:0]  sel;
  logic        busy;
  logic        err_stb;
  logic [31:0] err_addr;

  int vectors     = 0;
  int miscompares = 0;

  m68k_bus_arbiter_nreg dut (
    .clk      (clk),
    .rst      (rst),
    .ts_n     (ts_n),
    .a        (a),
    .rw       (rw),
    .siz      (siz),
    .ta_n     (ta_n),
    .tea_n    (tea_n),
    .tbi_n    (tbi_n),
    .sel      (sel),
    .ext_ack  (ext_ack),
    .busy     (busy),
    .err_stb  (err_stb),
    .err_addr (err_addr)
  );

  initial clk = 1'b0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Region table: tag in a[31:28], wait states, external ack, line support.
  int unsigned tag_tab   [4] = '{32'h0, 32'h2, 32'h3, 32'h8};
  int          wait_tab  [4] = '{2, 3, 5, 0};
  bit          ext_tab   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit          burst_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  // Model state: one transaction in flight, beat timing measured in edges.
  int          cyc          = 0;
  bit          m_active     = 1'b0;
  int          m_reg        = 0;
  int          m_beats_left = 0;
  int          m_beat_start = 0;
  bit          m_inhibit    = 1'b0;
  int          m_pulse      = 0;
  logic [31:0] m_addr       = '0;

  logic        e_ta    = 1'b1;
  logic        e_tea   = 1'b1;
  logic        e_tbi   = 1'b1;
  logic        e_busy  = 1'b0;
  logic        e_stb   = 1'b0;
  logic [3:0]  e_sel   = '0;
  logic [31:0] e_eaddr = '0;

  task automatic check_output(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Transaction model: predicts the outputs that follow each clock edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_pulse = 0; m_beats_left = 0; m_inhibit = 1'b0;
      e_ta = 1'b1; e_tea = 1'b1; e_tbi = 1'b1; e_busy = 1'b0; e_stb = 1'b0;
      e_sel = '0; e_eaddr = '0;
    end else begin
      cyc++;
      e_ta = 1'b1; e_tea = 1'b1; e_tbi = 1'b1; e_stb = 1'b0;
      if (m_pulse == 1) begin
        m_pulse = 0;
        if (m_beats_left > 0) begin
          m_beats_left--;
          m_beat_start = cyc;
        end else begin
          m_active = 1'b0; e_sel = '0; e_busy = 1'b0;
        end
      end else if (m_pulse == 2) begin
        m_pulse = 0; m_active = 1'b0; e_busy = 1'b0;
      end else if (m_active) begin
        int el;
        el = cyc - m_beat_start;
        if (ext_tab[m_reg] ? (ext_ack[m_reg] === 1'b1) : (el == wait_tab[m_reg] + 1)) begin
          e_ta = 1'b0; e_tbi = ~m_inhibit; m_pulse = 1;
        end else if (ext_tab[m_reg] && el >= TIMEOUT) begin
          e_tea = 1'b0; e_stb = 1'b1; e_eaddr = m_addr; e_sel = '0; m_pulse = 2;
        end
      end else if (ts_n === 1'b0) begin
        int r;
        r = -1;
        for (int i = 3; i >= 0; i--) begin
          if (a[31:28] == tag_tab[i][3:0]) r = i;
        end
        m_active = 1'b1; e_busy = 1'b1; m_addr = a;
        if (r < 0) begin
          e_tea = 1'b0; e_stb = 1'b1; e_eaddr = a; e_sel = '0; m_pulse = 2;
        end else begin
          m_reg        = r;
          e_sel        = 4'(1 << r);
          m_beats_left = (siz == 2'b11 && burst_tab[r]) ? 3 : 0;
          m_inhibit    = (siz == 2'b11) && !burst_tab[r];
          m_beat_start = cyc;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check_output("ta_n",     {31'd0, ta_n},    {31'd0, e_ta});
    check_output("tea_n",    {31'd0, tea_n},   {31'd0, e_tea});
    check_output("tbi_n",    {31'd0, tbi_n},   {31'd0, e_tbi});
    check_output("sel",      {28'd0, sel},     {28'd0, e_sel});
    check_output("busy",     {31'd0, busy},    {31'd0, e_busy});
    check_output("err_stb",  {31'd0, err_stb}, {31'd0, e_stb});
    check_output("err_addr", err_addr,         e_eaddr);
  end

  // Drive one TS pulse; returns on the falling edge after the sampling edge.
  task automatic apply_stimulus(input logic [31:0] addr, input logic [1:0] sz,
                                input logic dir);
    @(negedge clk);
    ts_n = 1'b0; a = addr; siz = sz; rw = dir;
    @(negedge clk);
    ts_n = 1'b1; a = '0; siz = 2'b00;
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Directed sequence with literal expectations at the key clocks.
  initial begin
    int ta_cnt;
    int tbi_cnt;
    int tea_cnt;
    rst = 1'b1; ts_n = 1'b1; a = '0; rw = 1'b1; siz = 2'b00; ext_ack = '0;
    skip(3);
    check_output("rst_ta_n",     {31'd0, ta_n},  32'd1);
    check_output("rst_sel",      {28'd0, sel},   32'd0);
    check_output("rst_busy",     {31'd0, busy},  32'd0);
    check_output("rst_err_addr", err_addr,       32'd0);
    rst = 1'b0;
    skip(2);

    $display("[TB] long read, region 0, two wait states");
    apply_stimulus(32'h0000_1000, 2'b00, 1'b1);
    check_output("t1_sel",  {28'd0, sel},  32'h1);
    check_output("t1_busy", {31'd0, busy}, 32'd1);
    skip(3);
    check_output("t1_ta_low", {31'd0, ta_n},  32'd0);
    check_output("t1_tbi",    {31'd0, tbi_n}, 32'd1);
    skip(1);
    check_output("t1_ta_high", {31'd0, ta_n}, 32'd1);
    check_output("t1_idle",    {31'd0, busy}, 32'd0);
    skip(2);

    $display("[TB] line read, region 0, four beats");
    apply_stimulus(32'h0000_0100, 2'b11, 1'b1);
    ta_cnt = 0; tbi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (ta_n == 1'b0) ta_cnt++;
      if (tbi_n == 1'b0) tbi_cnt++;
      skip(1);
    end
    check_output("t2_beats", ta_cnt,  32'd4);
    check_output("t2_tbi",   tbi_cnt, 32'd0);
    check_output("t2_busy",  {31'd0, busy}, 32'd0);

    $display("[TB] line read, region 2, external ack, burst inhibit");
    apply_stimulus(32'h3000_0000, 2'b11, 1'b1);
    check_output("t3_sel", {28'd0, sel}, 32'h4);
    skip(2);
    ext_ack = 4'b0010;
    skip(1);
    ext_ack = 4'b0000;
    skip(2);
    check_output("t3_no_early_ta", {31'd0, ta_n}, 32'd1);
    ext_ack = 4'b0100;
    skip(1);
    check_output("t3_ta",  {31'd0, ta_n},  32'd0);
    check_output("t3_tbi", {31'd0, tbi_n}, 32'd0);
    ext_ack = 4'b0000;
    skip(1);
    check_output("t3_done", {31'd0, busy}, 32'd0);
    skip(1);

    $display("[TB] unmapped access");
    apply_stimulus(32'h5000_0000, 2'b00, 1'b0);
    check_output("t4_tea",      {31'd0, tea_n},   32'd0);
    check_output("t4_stb",      {31'd0, err_stb}, 32'd1);
    check_output("t4_err_addr", err_addr,         32'h5000_0000);
    check_output("t4_ta",       {31'd0, ta_n},    32'd1);
    skip(1);
    check_output("t4_tea_end",  {31'd0, tea_n},   32'd1);
    check_output("t4_stb_end",  {31'd0, err_stb}, 32'd0);
    skip(1);

    $display("[TB] region 1 watchdog, ignored TS and foreign ack mid-wait");
    apply_stimulus(32'h2000_0040, 2'b00, 1'b1);
    check_output("t5_sel", {28'd0, sel}, 32'h2);
    skip(10);
    ts_n = 1'b0; a = 32'h0000_2000;
    skip(1);
    ts_n = 1'b1; a = '0;
    skip(9);
    ext_ack = 4'b0100;
    skip(1);
    ext_ack = 4'b0000;
    ta_cnt = 0; tea_cnt = 0;
    for (int i = 0; i < 233; i++) begin
      if (ta_n == 1'b0) ta_cnt++;
      if (tea_n == 1'b0) tea_cnt++;
      skip(1);
    end
    check_output("t5_no_ta",      ta_cnt,           32'd0);
    check_output("t5_no_early",   tea_cnt,          32'd0);
    skip(1);
    check_output("t5_tea",        {31'd0, tea_n},   32'd0);
    check_output("t5_err_addr",   err_addr,         32'h2000_0040);
    check_output("t5_stb",        {31'd0, err_stb}, 32'd1);
    skip(1);
    check_output("t5_idle",       {31'd0, busy},    32'd0);
    skip(1);

    $display("[TB] ack in the same clock as watchdog expiry");
    apply_stimulus(32'h2000_0080, 2'b10, 1'b0);
    skip(254);
    check_output("t6_pre_tea", {31'd0, tea_n}, 32'd1);
    ext_ack = 4'b0010;
    skip(1);
    check_output("t6_ta",  {31'd0, ta_n},  32'd0);
    check_output("t6_tea", {31'd0, tea_n}, 32'd1);
    ext_ack = 4'b0000;
    skip(1);
    check_output("t6_idle", {31'd0, busy}, 32'd0);
    skip(1);

    $display("[TB] reset during a line burst, then a fresh cycle");
    apply_stimulus(32'h0000_0200, 2'b11, 1'b1);
    check_output("t7_busy", {31'd0, busy}, 32'd1);
    skip(1);
    #2 rst = 1'b1;
    #1;
    check_output("t7_rst_ta",    {31'd0, ta_n},  32'd1);
    check_output("t7_rst_tea",   {31'd0, tea_n}, 32'd1);
    check_output("t7_rst_sel",   {28'd0, sel},   32'd0);
    check_output("t7_rst_busy",  {31'd0, busy},  32'd0);
    check_output("t7_rst_eaddr", err_addr,       32'd0);
    skip(1);
    #2 rst = 1'b0;
    apply_stimulus(32'h8000_0000, 2'b11, 1'b0);
    check_output("t7_sel", {28'd0, sel}, 32'h8);
    skip(1);
    check_output("t7_ta",  {31'd0, ta_n},  32'd0);
    check_output("t7_tbi", {31'd0, tbi_n}, 32'd0);
    skip(1);
    check_output("t7_idle", {31'd0, busy}, 32'd0);
    skip(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
